// File: rtl/ara_pkg.sv
// Shared types for the Ara system AXI transaction limiter: FSM states, a default system
// AXI request/response pair and a counter-width helper.
package ara_pkg;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StDrained
   } axi_limiter_state_e;

   localparam int unsigned AxiAddrW = 32;
   localparam int unsigned AxiDataW = 32;
   localparam int unsigned AxiIdW   = 4;

   typedef struct packed {
      logic [AxiIdW-1:0]   id;
      logic [AxiAddrW-1:0] addr;
      logic [7:0]          len;
      logic [2:0]          size;
      logic [1:0]          burst;
      logic                lock;
      logic [3:0]          cache;
      logic [2:0]          prot;
      logic [3:0]          qos;
   } sys_axi_ax_t;

   typedef struct packed {
      logic [AxiDataW-1:0]   data;
      logic [AxiDataW/8-1:0] strb;
      logic                  last;
   } sys_axi_w_t;

   typedef struct packed {
      logic [AxiIdW-1:0] id;
      logic [1:0]        resp;
   } sys_axi_b_t;

   typedef struct packed {
      logic [AxiIdW-1:0]   id;
      logic [AxiDataW-1:0] data;
      logic [1:0]          resp;
      logic                last;
   } sys_axi_r_t;

   typedef struct packed {
      sys_axi_ax_t aw;
      logic        aw_valid;
      sys_axi_w_t  w;
      logic        w_valid;
      logic        b_ready;
      sys_axi_ax_t ar;
      logic        ar_valid;
      logic        r_ready;
   } sys_axi_req_t;

   typedef struct packed {
      logic       aw_ready;
      logic       ar_ready;
      logic       w_ready;
      logic       b_valid;
      sys_axi_b_t b;
      logic       r_valid;
      sys_axi_r_t r;
   } sys_axi_resp_t;

   // Bits needed to hold 0..max_val inclusive.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ara_txn_counter.sv
// Outstanding-transaction counter bounded to 0..Max; simultaneous inc/dec cancel out and an
// out-of-range step holds the count and trips an assertion.
module ara_txn_counter
   import ara_pkg::*;
#(
   parameter int unsigned  Max  = 8,
   localparam int unsigned CntW = cnt_w(Max)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            inc_i,
   input  logic            dec_i,
   output logic [CntW-1:0] count_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(Max);

   logic [CntW-1:0] count_q, count_d;

   assign count_o = count_q;
   assign full_o  = (count_q == MaxCnt);
   assign empty_o = (count_q == '0);

   always_comb begin
      count_d = count_q;
      case ({inc_i, dec_i})
         2'b10: if (!full_o) count_d = count_q + 1'b1;
         2'b01: if (!empty_o) count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   dec_at_zero_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec_i && !inc_i && empty_o));

   inc_at_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inc_i && !dec_i && full_o));

endmodule

// File: rtl/ara_axi_txn_limiter.sv
// Caps outstanding AR/AW bursts on the Ara system AXI port and quiesces traffic on drain_i.
// Define ARA_AXI_LIMITER_PERF_EN to add saturating AR/AW stall-cycle counters.
module ara_axi_txn_limiter
   import ara_pkg::*;
#(
   parameter int unsigned MaxReadTxns  = 8,
   parameter int unsigned MaxWriteTxns = 8,
   parameter type         axi_req_t    = sys_axi_req_t,
   parameter type         axi_resp_t   = sys_axi_resp_t
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            drain_i,
   input  axi_req_t                        slv_req_i,
   output axi_resp_t                       slv_resp_o,
   output axi_req_t                        mst_req_o,
   input  axi_resp_t                       mst_resp_i,
   output logic [cnt_w(MaxReadTxns)-1:0]   rd_outstanding_o,
   output logic [cnt_w(MaxWriteTxns)-1:0]  wr_outstanding_o,
   output logic                            drained_o
`ifdef ARA_AXI_LIMITER_PERF_EN
   ,
   output logic [31:0]                     rd_stall_cycles_o,
   output logic [31:0]                     wr_stall_cycles_o
`endif
);

   axi_limiter_state_e state_q;
   logic               drained_q;
   logic               ar_pend_q, ar_pend_d;
   logic               aw_pend_q, aw_pend_d;
   logic               rd_full, rd_empty, wr_full, wr_empty;
   logic               ar_block, aw_block;
   logic               ar_hs, aw_hs, r_last_hs, b_hs;
   logic               quiet;

   // A burst already shown to memory overrides the gate so its valid is never withdrawn.
   always_comb begin
      ar_block = (rd_full || (state_q != StRun)) && !ar_pend_q;
      aw_block = (wr_full || (state_q != StRun)) && !aw_pend_q;

      mst_req_o          = slv_req_i;
      mst_req_o.ar_valid = slv_req_i.ar_valid && !ar_block;
      mst_req_o.aw_valid = slv_req_i.aw_valid && !aw_block;

      slv_resp_o          = mst_resp_i;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready && !ar_block;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready && !aw_block;

      ar_hs     = slv_req_i.ar_valid && !ar_block && mst_resp_i.ar_ready;
      aw_hs     = slv_req_i.aw_valid && !aw_block && mst_resp_i.aw_ready;
      r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
      b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;

      ar_pend_d = slv_req_i.ar_valid && !ar_block && !mst_resp_i.ar_ready;
      aw_pend_d = slv_req_i.aw_valid && !aw_block && !mst_resp_i.aw_ready;

      quiet = rd_empty && wr_empty && !ar_pend_q && !aw_pend_q;
   end

   ara_txn_counter #(
      .Max (MaxReadTxns)
   ) u_rd_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (ar_hs),
      .dec_i   (r_last_hs),
      .count_o (rd_outstanding_o),
      .full_o  (rd_full),
      .empty_o (rd_empty)
   );

   ara_txn_counter #(
      .Max (MaxWriteTxns)
   ) u_wr_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (aw_hs),
      .dec_i   (b_hs),
      .count_o (wr_outstanding_o),
      .full_o  (wr_full),
      .empty_o (wr_empty)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StRun;
         drained_q <= 1'b0;
         ar_pend_q <= 1'b0;
         aw_pend_q <= 1'b0;
      end else begin
         ar_pend_q <= ar_pend_d;
         aw_pend_q <= aw_pend_d;
         case (state_q)
            StRun: begin
               if (drain_i) state_q <= StDrain;
            end
            StDrain: begin
               if (!drain_i) begin
                  state_q <= StRun;
               end else if (quiet) begin
                  state_q   <= StDrained;
                  drained_q <= 1'b1;
               end
            end
            StDrained: begin
               if (!drain_i) begin
                  state_q   <= StRun;
                  drained_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= StRun;
               drained_q <= 1'b0;
            end
         endcase
      end
   end

   assign drained_o = drained_q;

`ifdef ARA_AXI_LIMITER_PERF_EN
   logic [31:0] rd_stall_q, rd_stall_d;
   logic [31:0] wr_stall_q, wr_stall_d;

   always_comb begin
      rd_stall_d = rd_stall_q;
      wr_stall_d = wr_stall_q;
      if (slv_req_i.ar_valid && ar_block && (rd_stall_q != '1)) rd_stall_d = rd_stall_q + 1'b1;
      if (slv_req_i.aw_valid && aw_block && (wr_stall_q != '1)) wr_stall_d = wr_stall_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_stall_q <= '0;
         wr_stall_q <= '0;
      end else begin
         rd_stall_q <= rd_stall_d;
         wr_stall_q <= wr_stall_d;
      end
   end

   assign rd_stall_cycles_o = rd_stall_q;
   assign wr_stall_cycles_o = wr_stall_q;
`endif

endmodule

// File: tb/tb_ara_axi_txn_limiter.sv
// Randomized scoreboard bench for ara_axi_txn_limiter; per-cycle expectations come from a
// transaction-level model of outstanding bursts and the drain mode.
module tb_ara_axi_txn_limiter;
   import ara_pkg::*;

   localparam int unsigned MaxRd = 2;
   localparam int unsigned MaxWr = 3;
   localparam int ModeRun      = 0;
   localparam int ModeDraining = 1;
   localparam int ModeDrained  = 2;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          drain   = 1'b0;
   sys_axi_req_t  slv_req = '0;
   sys_axi_req_t  mst_req;
   sys_axi_resp_t slv_resp;
   sys_axi_resp_t mst_resp = '0;
   logic [$clog2(MaxRd+1)-1:0] rd_outstanding;
   logic [$clog2(MaxWr+1)-1:0] wr_outstanding;
   logic          drained;
`ifdef ARA_AXI_LIMITER_PERF_EN
   logic [31:0]   rd_stall;
   logic [31:0]   wr_stall;
`endif

   always #5 clk = ~clk;

   ara_axi_txn_limiter #(
      .MaxReadTxns  (MaxRd),
      .MaxWriteTxns (MaxWr),
      .axi_req_t    (sys_axi_req_t),
      .axi_resp_t   (sys_axi_resp_t)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .drain_i          (drain),
      .slv_req_i        (slv_req),
      .slv_resp_o       (slv_resp),
      .mst_req_o        (mst_req),
      .mst_resp_i       (mst_resp),
      .rd_outstanding_o (rd_outstanding),
      .wr_outstanding_o (wr_outstanding),
      .drained_o        (drained)
`ifdef ARA_AXI_LIMITER_PERF_EN
      ,
      .rd_stall_cycles_o(rd_stall),
      .wr_stall_cycles_o(wr_stall)
`endif
   );

   typedef struct {
      logic                ar_v, ar_r, aw_v, aw_r, w_v, r_v, b_v, drained;
      logic [AxiDataW-1:0] w_data, r_data;
      int unsigned         rd, wr, rd_st, wr_st;
   } exp_t;

   // Percent knobs per phase; drain: 0/1 fixed, 2 random toggling. rst: 1 forced, 2 rare random.
   typedef struct packed {
      int cyc; int p_ar; int p_aw; int p_ardy; int p_awrdy; int p_w;
      int p_r; int p_last; int p_b; int drain; int rst;
   } phase_t;

   exp_t                sb_q[$];
   logic [AxiAddrW-1:0] ar_q[$];
   logic [AxiAddrW-1:0] aw_q[$];
   int unsigned         n_vec = 0;
   int unsigned         n_err = 0;

   int unsigned m_rd, m_wr, m_rd_st, m_wr_st;
   int          m_mode;
   bit          m_ar_shown, m_aw_shown, hold_ar, hold_aw;

   function automatic bit pct(input int p);
      return int'($urandom_range(99, 0)) < p;
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_addr(input string name, input logic [AxiAddrW-1:0] act,
                                    inout logic [AxiAddrW-1:0] q[$]);
      n_vec++;
      if (q.size() == 0) begin
         n_err++;
         $display("FAIL %s: got handshake at %0h, expected none queued at %0t", name, act, $time);
      end else begin
         logic [AxiAddrW-1:0] exp_a;
         exp_a = q.pop_front();
         if (act !== exp_a) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_a, $time);
         end
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("mst_ar_valid", 64'(mst_req.ar_valid), 64'(e.ar_v));
         chk("slv_ar_ready", 64'(slv_resp.ar_ready), 64'(e.ar_r));
         chk("mst_aw_valid", 64'(mst_req.aw_valid), 64'(e.aw_v));
         chk("slv_aw_ready", 64'(slv_resp.aw_ready), 64'(e.aw_r));
         chk("mst_w_valid", 64'(mst_req.w_valid), 64'(e.w_v));
         chk("mst_w_data", 64'(mst_req.w.data), 64'(e.w_data));
         chk("slv_r_valid", 64'(slv_resp.r_valid), 64'(e.r_v));
         chk("slv_r_data", 64'(slv_resp.r.data), 64'(e.r_data));
         chk("slv_b_valid", 64'(slv_resp.b_valid), 64'(e.b_v));
         chk("rd_outstanding", 64'(rd_outstanding), 64'(e.rd));
         chk("wr_outstanding", 64'(wr_outstanding), 64'(e.wr));
         chk("drained", 64'(drained), 64'(e.drained));
`ifdef ARA_AXI_LIMITER_PERF_EN
         chk("rd_stall_cycles", 64'(rd_stall), 64'(e.rd_st));
         chk("wr_stall_cycles", 64'(wr_stall), 64'(e.wr_st));
`endif
         if (mst_req.ar_valid === 1'b1 && mst_resp.ar_ready === 1'b1)
            chk_addr("mst_ar_addr", mst_req.ar.addr, ar_q);
         if (mst_req.aw_valid === 1'b1 && mst_resp.aw_ready === 1'b1)
            chk_addr("mst_aw_addr", mst_req.aw.addr, aw_q);
      end
   end

   task automatic step(input phase_t p);
      exp_t e;
      bit   rst_cyc, rd_open, wr_open, ar_acc, aw_acc, r_done, b_done, idle;
      logic ardy, awrdy;

      rst_cyc = (p.rst == 1) || (p.rst == 2 && pct(1));
      rst_n   = !rst_cyc;
      if (p.drain == 2) begin
         if (pct(4)) drain = !drain;
      end else begin
         drain = (p.drain == 1);
      end

      if (rst_cyc) begin
         hold_ar = 1'b0;
         hold_aw = 1'b0;
         ar_q.delete();
         aw_q.delete();
         slv_req.ar_valid = 1'b0;
         slv_req.aw_valid = 1'b0;
      end else begin
         if (!hold_ar) begin
            slv_req.ar_valid = pct(p.p_ar);
            if (slv_req.ar_valid) begin
               slv_req.ar.addr = $urandom;
               slv_req.ar.len  = 8'($urandom);
               ar_q.push_back(slv_req.ar.addr);
            end
         end
         if (!hold_aw) begin
            slv_req.aw_valid = pct(p.p_aw);
            if (slv_req.aw_valid) begin
               slv_req.aw.addr = $urandom;
               slv_req.aw.len  = 8'($urandom);
               aw_q.push_back(slv_req.aw.addr);
            end
         end
      end
      slv_req.w_valid = !rst_cyc && pct(p.p_w);
      slv_req.w.data  = $urandom;
      slv_req.w.last  = 1'($urandom);
      slv_req.r_ready = 1'b1;
      slv_req.b_ready = 1'b1;

      ardy                = pct(p.p_ardy);
      awrdy               = pct(p.p_awrdy);
      mst_resp.ar_ready   = ardy;
      mst_resp.aw_ready   = awrdy;
      mst_resp.w_ready    = 1'($urandom);
      mst_resp.r_valid    = !rst_cyc && (m_rd > 0) && pct(p.p_r);
      mst_resp.r.last     = pct(p.p_last);
      mst_resp.r.data     = $urandom;
      mst_resp.b_valid    = !rst_cyc && (m_wr > 0) && pct(p.p_b);
      mst_resp.b.resp     = 2'($urandom);

      // A burst already offered to memory stays offered; otherwise only RUN with room admits.
      rd_open = m_ar_shown || (m_mode == ModeRun && m_rd < MaxRd);
      wr_open = m_aw_shown || (m_mode == ModeRun && m_wr < MaxWr);

      e.ar_v    = slv_req.ar_valid && rd_open;
      e.ar_r    = ardy && rd_open;
      e.aw_v    = slv_req.aw_valid && wr_open;
      e.aw_r    = awrdy && wr_open;
      e.w_v     = slv_req.w_valid;
      e.w_data  = slv_req.w.data;
      e.r_v     = mst_resp.r_valid;
      e.r_data  = mst_resp.r.data;
      e.b_v     = mst_resp.b_valid;
      e.rd      = m_rd;
      e.wr      = m_wr;
      e.drained = (m_mode == ModeDrained);
      e.rd_st   = m_rd_st;
      e.wr_st   = m_wr_st;
      sb_q.push_back(e);

      if (rst_cyc) begin
         m_rd       = 0;
         m_wr       = 0;
         m_rd_st    = 0;
         m_wr_st    = 0;
         m_mode     = ModeRun;
         m_ar_shown = 1'b0;
         m_aw_shown = 1'b0;
      end else begin
         ar_acc = e.ar_v && ardy;
         aw_acc = e.aw_v && awrdy;
         r_done = mst_resp.r_valid && mst_resp.r.last;
         b_done = mst_resp.b_valid;
         idle   = (m_rd == 0) && (m_wr == 0) && !m_ar_shown && !m_aw_shown;
         case (m_mode)
            ModeRun:      if (drain) m_mode = ModeDraining;
            ModeDraining: if (!drain) m_mode = ModeRun; else if (idle) m_mode = ModeDrained;
            default:      if (!drain) m_mode = ModeRun;
         endcase
         if (ar_acc) m_rd++;
         if (r_done) m_rd--;
         if (aw_acc) m_wr++;
         if (b_done) m_wr--;
         if (slv_req.ar_valid && !rd_open) m_rd_st++;
         if (slv_req.aw_valid && !wr_open) m_wr_st++;
         m_ar_shown = e.ar_v && !ardy;
         m_aw_shown = e.aw_v && !awrdy;
         hold_ar    = slv_req.ar_valid && !e.ar_r;
         hold_aw    = slv_req.aw_valid && !e.aw_r;
      end
   endtask

   phase_t ph[17];

   initial begin
      //        cyc  ar   aw  ardy awrdy  w    r  last   b  drn rst
      ph = '{
         '{  6, 100,   0, 100, 100,   0,   0,   0,   0, 0, 0},  // reads fill to the cap
         '{  4, 100,   0, 100, 100,   0, 100, 100,   0, 0, 0},  // R last frees a slot
         '{  4,   0,   0, 100, 100,   0, 100, 100,   0, 0, 0},
         '{  6,   0, 100, 100, 100, 100,   0,   0,   0, 0, 0},  // writes full, W still flows
         '{  3,   0, 100, 100, 100,  50,   0,   0,  40, 0, 0},
         '{  4, 100,   0, 100, 100,   0,   0,   0,   0, 0, 0},
         '{ 16, 100, 100, 100, 100,  50,  50, 100,  50, 1, 0},  // drain with traffic in flight
         '{  3, 100, 100, 100, 100,   0,   0,   0,   0, 1, 0},
         '{  3,   0,   0, 100, 100,   0,  50, 100,  50, 0, 0},
         '{  6,   0,   0, 100, 100,   0, 100, 100, 100, 0, 0},
         '{  4, 100,   0,   0, 100,   0,   0,   0,   0, 0, 0},  // AR stalled by memory
         '{  3, 100,   0,   0, 100,   0,   0,   0,   0, 1, 0},  // drain while AR is stalled
         '{ 10, 100,   0, 100, 100,   0,  60, 100,   0, 1, 0},
         '{  4, 100, 100, 100, 100,  50,  30,  50,  30, 0, 0},
         '{  1,   0,   0,  50,  50,   0,   0,   0,   0, 0, 1},  // reset mid-operation
         '{600,  60,  60,  70,  70,  50,  50,  50,  50, 2, 2},
         '{ 24,   0,   0, 100, 100,   0,  80, 100,  80, 1, 0}
      };
      m_rd       = 0;
      m_wr       = 0;
      m_rd_st    = 0;
      m_wr_st    = 0;
      m_mode     = ModeRun;
      m_ar_shown = 1'b0;
      m_aw_shown = 1'b0;
      hold_ar    = 1'b0;
      hold_aw    = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      foreach (ph[i]) begin
         for (int c = 0; c < ph[i].cyc; c++) begin
            #1;
            step(ph[i]);
            @(posedge clk);
         end
      end
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
